// File: rtl/collision_detector.sv
// Bus collision detector for the open-drain controller data line: flags when this node releases
// the line but another device holds it low. Optional COLLISION_DETECTOR_COUNT_EN adds an event count.
module collision_detector #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned MISMATCH_CYCLES = 3,
    parameter int unsigned BLANK_CYCLES    = 2
) (
    input  logic       CLK,
    input  logic       n_RST,
    input  logic       WRITE_DATA,
    input  logic       n_SEND,
    input  logic       DATALINE,
`ifdef COLLISION_DETECTOR_COUNT_EN
    output logic [7:0] COLLISION_COUNT,
`endif
    output logic       COLLISION_DETECTED
);

    localparam logic [3:0] MIS_MAX    = 4'(MISMATCH_CYCLES);
    localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES);

    logic [SYNC_STAGES-1:0] r_line_sync;
    logic [SYNC_STAGES-1:0] r_wd_pipe;
    logic [SYNC_STAGES-1:0] r_ns_pipe;
    logic                   r_wd_prev;
    logic [3:0]             r_blank_cnt;
    logic [3:0]             r_mis_cnt;
    logic                   r_flag;

    logic       w_line_s;
    logic       w_wd_d;
    logic       w_ns_d;
    logic       w_wd_rise;
    logic       w_mismatch;
    logic [3:0] w_blank_next;
    logic [3:0] w_mis_next;
    logic       w_flag_next;

    assign w_line_s = r_line_sync[SYNC_STAGES-1];
    assign w_wd_d   = r_wd_pipe[SYNC_STAGES-1];
    assign w_ns_d   = r_ns_pipe[SYNC_STAGES-1];

    // WRITE_DATA/n_SEND ride a pipe as deep as the synchronizer so all three stay cycle-aligned.
    always_ff @(posedge CLK or negedge n_RST) begin
        if (!n_RST) begin
            r_line_sync <= '1;
            r_wd_pipe   <= '1;
            r_ns_pipe   <= '1;
            r_wd_prev   <= 1'b1;
        end else begin
            r_line_sync <= {r_line_sync[SYNC_STAGES-2:0], DATALINE};
            r_wd_pipe   <= {r_wd_pipe[SYNC_STAGES-2:0], WRITE_DATA};
            r_ns_pipe   <= {r_ns_pipe[SYNC_STAGES-2:0], n_SEND};
            r_wd_prev   <= w_wd_d;
        end
    end

    always_comb begin
        w_wd_rise  = w_wd_d & ~r_wd_prev & ~w_ns_d;
        w_mismatch = ~w_ns_d & w_wd_d & ~w_line_s & (r_blank_cnt == 4'd0);

        w_blank_next = r_blank_cnt;
        if (w_ns_d) begin
            w_blank_next = 4'd0;
        end else if (w_wd_rise) begin
            w_blank_next = BLANK_LOAD;
        end else if (r_blank_cnt != 4'd0) begin
            w_blank_next = r_blank_cnt - 4'd1;
        end

        // Not sending, blanking and a matching line all fall out of w_mismatch being low.
        w_mis_next = 4'd0;
        if (w_mismatch) begin
            w_mis_next = (r_mis_cnt == MIS_MAX) ? r_mis_cnt : r_mis_cnt + 4'd1;
        end

        w_flag_next = 1'b0;
        if (!w_ns_d) begin
            w_flag_next = r_flag | (w_mis_next == MIS_MAX);
        end
    end

    always_ff @(posedge CLK or negedge n_RST) begin
        if (!n_RST) begin
            r_blank_cnt <= 4'd0;
            r_mis_cnt   <= 4'd0;
            r_flag      <= 1'b0;
        end else begin
            r_blank_cnt <= w_blank_next;
            r_mis_cnt   <= w_mis_next;
            r_flag      <= w_flag_next;
        end
    end

    assign COLLISION_DETECTED = r_flag;

`ifdef COLLISION_DETECTOR_COUNT_EN
    logic [7:0] r_coll_count;

    // Counts flag rising edges only; n_SEND never clears it.
    always_ff @(posedge CLK or negedge n_RST) begin
        if (!n_RST) begin
            r_coll_count <= 8'd0;
        end else if (w_flag_next && !r_flag && (r_coll_count != 8'hFF)) begin
            r_coll_count <= r_coll_count + 8'd1;
        end
    end

    assign COLLISION_COUNT = r_coll_count;
`endif

endmodule

// File: tb/tb_collision_detector.sv
// Scoreboard bench for collision_detector: stimulus queues expected flag/count values per cycle,
// a negedge monitor pops and compares them.
module tb_collision_detector;

    logic CLK = 1'b0;
    logic n_RST;
    logic WRITE_DATA;
    logic n_SEND;
    logic DATALINE;
    logic COLLISION_DETECTED;
`ifdef COLLISION_DETECTOR_COUNT_EN
    logic [7:0] COLLISION_COUNT;
`endif

    collision_detector dut (
        .CLK                (CLK),
        .n_RST              (n_RST),
        .WRITE_DATA         (WRITE_DATA),
        .n_SEND             (n_SEND),
        .DATALINE           (DATALINE),
`ifdef COLLISION_DETECTOR_COUNT_EN
        .COLLISION_COUNT    (COLLISION_COUNT),
`endif
        .COLLISION_DETECTED (COLLISION_DETECTED)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       exp;
        bit         is_cnt;
        logic [7:0] exp_cnt;
        string      name;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void push_f(int off, logic v, string nm);
        chk_t c;
        c.cyc = cyc + off; c.exp = v; c.is_cnt = 1'b0; c.exp_cnt = 8'd0; c.name = nm;
        q.push_back(c);
    endfunction

    function automatic void push_c(int off, logic [7:0] v, string nm);
`ifdef COLLISION_DETECTOR_COUNT_EN
        chk_t c;
        c.cyc = cyc + off; c.exp = 1'b0; c.is_cnt = 1'b1; c.exp_cnt = v; c.name = nm;
        q.push_back(c);
`else
        if (off < 0 && v == 8'd0 && nm == "") q.delete();
`endif
    endfunction

    // Monitor: compares every queued expectation due at this cycle.
    chk_t m;
    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m = q.pop_front();
            checks++;
            if (m.cyc < cyc) begin
                errors++;
                $display("FAIL %s: check due at cycle %0d missed (now %0d)", m.name, m.cyc, cyc);
            end else if (!m.is_cnt) begin
                if (COLLISION_DETECTED !== m.exp) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: COLLISION_DETECTED=%b expected %b",
                             m.name, cyc, COLLISION_DETECTED, m.exp);
                end
            end
`ifdef COLLISION_DETECTOR_COUNT_EN
            else if (COLLISION_COUNT !== m.exp_cnt) begin
                errors++;
                $display("FAIL %s @cycle %0d: COLLISION_COUNT=%0d expected %0d",
                         m.name, cyc, COLLISION_COUNT, m.exp_cnt);
            end
`endif
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic hold_check(int n, logic v, string nm);
        repeat (n) begin
            push_f(0, v, nm);
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic pat [5];
        logic prev;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        n_RST = 1'b0; n_SEND = 1'b1; WRITE_DATA = 1'b1; DATALINE = 1'b1;
        step(); step();
        push_f(0, 1'b0, "reset_flag");
        push_c(0, 8'd0, "reset_count");
        step();
        n_RST = 1'b1;
        step();

        // Idle: WRITE_DATA toggles, line high then forced low.
        for (int i = 0; i < 24; i++) begin
            WRITE_DATA = i[0];
            DATALINE   = (i < 4);
            push_f(0, 1'b0, "idle");
            step();
        end
        WRITE_DATA = 1'b1; DATALINE = 1'b1;

        // Clean send, line follows WRITE_DATA with a one-cycle rise delay.
        n_SEND = 1'b0;
        prev   = 1'b1;
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 4; k++) begin
                WRITE_DATA = pat[p];
                DATALINE   = pat[p] & prev;
                prev       = pat[p];
                push_f(0, 1'b0, "clean_send");
                step();
            end
        end
        WRITE_DATA = 1'b1; DATALINE = 1'b0;
        push_f(0, 1'b0, "clean_rise");
        step();
        DATALINE = 1'b1;
        hold_check(6, 1'b0, "clean_tail");

        // Collision: flag rises exactly 5 edges after the line drops.
        DATALINE = 1'b0;
        push_f(4, 1'b0, "coll_before");
        push_c(4, 8'd0, "coll_count_before");
        push_f(5, 1'b1, "coll_rise");
        push_c(5, 8'd1, "coll_count");
        for (int o = 6; o < 10; o++) push_f(o, 1'b1, "coll_sticky");
        repeat (10) step();

        // n_SEND release clears the flag 3 edges later; count survives.
        n_SEND = 1'b1;
        push_f(2, 1'b1, "clr_before");
        push_f(3, 1'b0, "clr");
        push_c(4, 8'd1, "count_survives_clr");
        repeat (5) step();
        DATALINE = 1'b1;
        hold_check(3, 1'b0, "idle_after_clr");

        // Glitch rejection: 2-cycle low ignored, 3-cycle low sets.
        n_SEND = 1'b0; WRITE_DATA = 1'b1;
        hold_check(6, 1'b0, "glitch_settle");
        DATALINE = 1'b0;
        for (int o = 0; o < 9; o++) push_f(o, 1'b0, "glitch2");
        step(); step();
        DATALINE = 1'b1;
        repeat (7) step();
        DATALINE = 1'b0;
        push_f(4, 1'b0, "glitch3_before");
        push_f(5, 1'b1, "glitch3_set");
        push_f(8, 1'b1, "glitch3_hold");
        repeat (3) step();
        DATALINE = 1'b1;
        repeat (6) step();
        n_SEND = 1'b1;
        push_f(3, 1'b0, "glitch_clr");
        repeat (4) step();

        // Blanking after WRITE_DATA 0->1 with a slow line.
        n_SEND = 1'b0; WRITE_DATA = 1'b0; DATALINE = 1'b0;
        hold_check(6, 1'b0, "blank_settle");
        WRITE_DATA = 1'b1;
        for (int o = 0; o < 9; o++) push_f(o, 1'b0, "blank2");
        step(); step();
        DATALINE = 1'b1;
        repeat (7) step();
        WRITE_DATA = 1'b0; DATALINE = 1'b0;
        hold_check(4, 1'b0, "blank_relow");
        WRITE_DATA = 1'b1;
        push_f(7, 1'b0, "blank6_before");
        push_f(8, 1'b1, "blank6_set");
        repeat (6) step();
        DATALINE = 1'b1;
        repeat (3) step();
        n_SEND = 1'b1;
        push_f(3, 1'b0, "blank_clr");
        repeat (4) step();

        // n_SEND rise lands on the same edge the threshold would be reached: clear wins.
        n_SEND = 1'b0;
        hold_check(6, 1'b0, "cw_settle");
        DATALINE = 1'b0;
        for (int o = 0; o < 8; o++) push_f(o, 1'b0, "clear_wins");
        step(); step();
        n_SEND = 1'b1;
        repeat (6) step();
        DATALINE = 1'b1;

        // Asynchronous reset mid-collision.
        n_SEND = 1'b0;
        hold_check(6, 1'b0, "rst_settle");
        DATALINE = 1'b0;
        push_f(5, 1'b1, "rst_coll_set");
        push_c(5, 8'd4, "count_total");
        repeat (6) step();
        n_RST = 1'b0;
        push_f(0, 1'b0, "async_reset");
        push_c(0, 8'd0, "count_reset");
        @(negedge CLK);
        #2;
        n_RST = 1'b1; n_SEND = 1'b1; DATALINE = 1'b1;
        step();
        hold_check(5, 1'b0, "post_reset");

        step(); step();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
